data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder that services the load/store requests issued by the MEM stage.
- Accepts one request (address, write data, read/write strobes) and stalls the pipeline for a fixed latency. It then performs the access and presents read data with a one-cycle valid pulse.
- Replaces the single-cycle data RAM path so that slower backing memory can be modelled.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs; `stall` feeds the hazard unit.

---
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one load/store,
// stalls the pipeline for LATENCY cycles, then commits the access and pulses resp_valid.
module data_mem_responder #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic                  req_read,
   input  logic                  req_write,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_valid,
   output logic                  addr_err,
   output logic                  op_err
);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be in 1..15");
   end

   localparam logic [3:0] CntInit     = 4'(LATENCY - 1);
   localparam bit         SingleCycle = (LATENCY == 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

   state_t                  state;
   logic [3:0]              cnt;
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic                    lat_read;
   logic                    lat_write;
   logic                    lat_aerr;

   logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

   logic                    req;
   logic                    req_aerr;
   logic                    commit;
   logic [ADDR_WIDTH-1:0]   acc_addr;
   logic [DATA_WIDTH-1:0]   acc_wdata;
   logic                    acc_read;
   logic                    acc_write;
   logic                    acc_aerr;

   // Commit happens on the edge entering DONE; with single-cycle latency that edge is
   // the accept edge itself, so the live request is used instead of the latched copy.
   always_comb begin
      req       = req_read | req_write;
      req_aerr  = |(req_addr >> ADDR_WIDTH);
      commit    = 1'b0;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_read  = lat_read;
      acc_write = lat_write;
      acc_aerr  = lat_aerr;
      if (SingleCycle && state == StIdle && req) begin
         commit    = 1'b1;
         acc_addr  = req_addr[ADDR_WIDTH-1:0];
         acc_wdata = req_wdata;
         acc_read  = req_read;
         acc_write = req_write;
         acc_aerr  = req_aerr;
      end else if (state == StBusy && cnt == 4'd1) begin
         commit = 1'b1;
      end
   end

   assign stall = rst & (((state == StIdle) & req) | (state == StBusy));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= StIdle;
         cnt        <= 4'd0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_read   <= 1'b0;
         lat_write  <= 1'b0;
         lat_aerr   <= 1'b0;
         resp_rdata <= '0;
         resp_valid <= 1'b0;
         addr_err   <= 1'b0;
         op_err     <= 1'b0;
      end else begin
         resp_valid <= commit;
         addr_err   <= commit & acc_aerr;
         op_err     <= commit & acc_read & acc_write;
         // Write wins a read/write conflict, leaving resp_rdata untouched.
         if (commit && acc_read && !acc_write) begin
            resp_rdata <= mem[acc_addr];
         end
         unique case (state)
            StIdle: begin
               if (req) begin
                  lat_addr  <= req_addr[ADDR_WIDTH-1:0];
                  lat_wdata <= req_wdata;
                  lat_read  <= req_read;
                  lat_write <= req_write;
                  lat_aerr  <= req_aerr;
                  cnt       <= CntInit;
                  state     <= SingleCycle ? StDone : StBusy;
               end
            end
            StBusy: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= StDone;
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   // Backing array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (commit && acc_write) begin
         mem[acc_addr] <= acc_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances (LATENCY 2, 4, 1) driven by
// directed and random load/store sequences, checked against an array-based memory model.
module tb_data_mem_responder;

   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] rst;
   logic [N-1:0] req_read;
   logic [N-1:0] req_write;
   logic [N-1:0] stall;
   logic [N-1:0] resp_valid;
   logic [N-1:0] addr_err;
   logic [N-1:0] op_err;
   logic [31:0]  req_addr   [N];
   logic [31:0]  req_wdata  [N];
   logic [31:0]  resp_rdata [N];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem_m   [N][256];
   logic [31:0] rdata_m [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      data_mem_responder #(
         .ADDR_WIDTH(8),
         .DATA_WIDTH(32),
         .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 4 : 1))
      ) u_dut (
         .clk       (clk),
         .rst       (rst[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_read  (req_read[g]),
         .req_write (req_write[g]),
         .stall     (stall[g]),
         .resp_rdata(resp_rdata[g]),
         .resp_valid(resp_valid[g]),
         .addr_err  (addr_err[g]),
         .op_err    (op_err[g])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Issue one request; may be called in an IDLE cycle or in the DONE cycle of the
   // previous access (back-to-back). Returns at the DONE cycle of this access.
   task automatic access(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit rd, input bit wr, output int done_cyc);
      int         n;
      logic [7:0] a;
      bit         aerr_m;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      req_read[k]  = rd;
      req_write[k] = wr;
      #1;
      if (resp_valid[k]) begin
         check("no_accept_in_done", 32'(stall[k]), 32'd0);
         @(posedge clk); #1;
      end
      a      = addr[7:0];
      aerr_m = (addr[31:8] != 24'd0);
      if (wr) mem_m[k][a] = wdata;
      else if (rd) rdata_m[k] = mem_m[k][a];
      n = 0;
      while (stall[k] && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      check("stall_cycles", 32'(n), 32'(lat_of(k)));
      check("resp_valid", 32'(resp_valid[k]), 32'd1);
      check("resp_rdata", resp_rdata[k], rdata_m[k]);
      check("addr_err", 32'(addr_err[k]), 32'(aerr_m));
      check("op_err", 32'(op_err[k]), 32'(rd && wr));
      done_cyc = cyc;
   endtask

   task automatic idle(input int k);
      req_read[k]  = 1'b0;
      req_write[k] = 1'b0;
      @(posedge clk); #1;
      check("valid_one_cycle", 32'(resp_valid[k]), 32'd0);
      check("idle_no_stall", 32'(stall[k]), 32'd0);
      check("idle_no_flags", 32'({addr_err[k], op_err[k]}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          d1, d2;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          op;

      rst       = '0;
      req_read  = '0;
      req_write = '0;
      for (int k = 0; k < N; k++) begin
         req_addr[k]  = '0;
         req_wdata[k] = '0;
         rdata_m[k]   = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         check("rst_stall", 32'(stall[k]), 32'd0);
         check("rst_valid", 32'(resp_valid[k]), 32'd0);
         check("rst_rdata", resp_rdata[k], 32'd0);
         check("rst_flags", 32'({addr_err[k], op_err[k]}), 32'd0);
      end
      rst = '1;
      @(posedge clk); #1;

      // Instance 0 (LATENCY=2): directed cases
      access(0, 32'h05, 32'hDEADBEEF, 1'b0, 1'b1, d1); idle(0);
      access(0, 32'h05, 32'h0, 1'b1, 1'b0, d1); idle(0);
      access(0, 32'h01, 32'h11, 1'b0, 1'b1, d1);
      access(0, 32'h02, 32'h22, 1'b0, 1'b1, d1); idle(0);
      access(0, 32'h01, 32'h0, 1'b1, 1'b0, d1);
      access(0, 32'h02, 32'h0, 1'b1, 1'b0, d2);
      check("b2b_spacing", 32'(d2 - d1), 32'd3);
      idle(0);
      access(0, 32'h105, 32'hA5, 1'b0, 1'b1, d1); idle(0);
      access(0, 32'h05, 32'h0, 1'b1, 1'b0, d1); idle(0);
      access(0, 32'h07, 32'h1234, 1'b1, 1'b1, d1); idle(0);
      access(0, 32'h07, 32'h0, 1'b1, 1'b0, d1); idle(0);

      // Instance 0: random mix over a pre-written window, with aliasing upper bits
      for (int a = 0; a < 16; a++) access(0, 32'(a), $urandom, 1'b0, 1'b1, d1);
      idle(0);
      for (int i = 0; i < 60; i++) begin
         op    = int'($urandom_range(0, 2));
         addr  = 32'($urandom_range(0, 15));
         wdata = $urandom;
         if ($urandom_range(0, 3) == 0) addr[31:8] = 24'($urandom);
         access(0, addr, wdata, op != 1, op != 0, d1);
         if ($urandom_range(0, 1) == 1) idle(0);
      end
      idle(0);

      // Instance 1 (LATENCY=4): reset asserted mid-BUSY aborts the store
      access(1, 32'h09, 32'h0, 1'b0, 1'b1, d1); idle(1);
      access(1, 32'h03, 32'h55, 1'b0, 1'b1, d1); idle(1);
      access(1, 32'h03, 32'h0, 1'b1, 1'b0, d1); idle(1);
      req_addr[1]  = 32'h09;
      req_wdata[1] = 32'hFFFF;
      req_write[1] = 1'b1;
      req_read[1]  = 1'b0;
      #1;
      check("b_stall_accept", 32'(stall[1]), 32'd1);
      @(posedge clk); #1;
      check("b_stall_busy", 32'(stall[1]), 32'd1);
      rst[1]       = 1'b0;
      req_write[1] = 1'b0;
      rdata_m[1]   = '0;
      #1;
      check("async_rst_stall", 32'(stall[1]), 32'd0);
      check("async_rst_valid", 32'(resp_valid[1]), 32'd0);
      check("async_rst_rdata", resp_rdata[1], 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("rst_no_valid", 32'(resp_valid[1]), 32'd0);
      end
      rst[1] = 1'b1;
      @(posedge clk); #1;
      check("post_rst_valid", 32'(resp_valid[1]), 32'd0);
      access(1, 32'h09, 32'h0, 1'b1, 1'b0, d1); idle(1);

      // Instance 2 (LATENCY=1)
      access(2, 32'h20, 32'hCAFEF00D, 1'b0, 1'b1, d1); idle(2);
      access(2, 32'h20, 32'h0, 1'b1, 1'b0, d1);
      access(2, 32'h21, 32'h77, 1'b0, 1'b1, d2);
      check("l1_b2b_spacing", 32'(d2 - d1), 32'd2);
      idle(2);
      access(2, 32'h121, 32'h0, 1'b1, 1'b0, d1); idle(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
